// File: rtl/xy_scan_pkg.sv
// xy_scan_pkg: shared types and default geometry for the xy scan counter.
//   dir_e     : count direction (DIR_UP=0, DIR_DOWN=1)
//   DEF_*     : default channel widths, terminal values and frame counter width
package xy_scan_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEF_COL_WIDTH       = 3;
  localparam int DEF_ROW_WIDTH       = 2;
  localparam int DEF_COL_LIMIT       = 5;
  localparam int DEF_ROW_LIMIT       = 2;
  localparam int DEF_FRAME_CNT_WIDTH = 8;

endpackage

// File: rtl/xy_scan_counter_stage.sv
// scan_count_stage: one channel of the cascaded scan counter.
//   clk, reset : clock, synchronous active-high reset (value -> 0)
//   en         : step one position this cycle
//   dir        : 0 up, 1 down; selects start/terminal and step sign
//   load       : parallel load of load_val, clamped to LIMIT (beats en)
//   hold       : suppress the step (saturating end of frame)
//   load_val   : load value
//   value      : current position, always within 0..LIMIT
//   wrap       : combinational carry, en while sitting on the terminal value
module scan_count_stage
  import xy_scan_pkg::*;
#(
  parameter int WIDTH = DEF_COL_WIDTH,
  parameter int LIMIT = DEF_COL_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  if (LIMIT > (2**WIDTH) - 1) begin : g_bad_limit
    $error("scan_count_stage: LIMIT %0d does not fit in %0d bits", LIMIT, WIDTH);
  end

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_e             d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] start;

  assign d     = dir_e'(dir);
  // Terminal/start follow the current dir, so a mid-frame direction change
  // never jumps the value; it only changes where the next wrap happens.
  assign term  = (d == DIR_DOWN) ? '0  : LIM;
  assign start = (d == DIR_DOWN) ? LIM : '0;
  assign wrap  = en & (value == term);

  always_ff @(posedge clk) begin
    if (reset)
      value <= '0;
    else if (load)
      value <= (load_val > LIM) ? LIM : load_val;
    else if (en && !hold)
      value <= wrap ? start : ((d == DIR_DOWN) ? value - ONE : value + ONE);
  end

endmodule

// File: rtl/xy_scan_counter.sv
// xy_scan_counter: column counter cascaded into a row counter, producing
// (col,row) scan coordinates with line/frame pulses.
//   clk, reset     : clock, synchronous active-high reset
//   en             : advance one position
//   dir            : 0 up, 1 down (ignored when UP_DOWN_COUNT=0)
//   load           : load col_in/row_in (clamped to limits), clears done
//   col_in, row_in : load values
//   col, row       : current position
//   line_end       : 1-cycle pulse with the first value after a column wrap
//   frame_end      : 1-cycle pulse with the first value after a frame wrap
//   done           : SATURATE=1 only, level after the frame completes
//   frame_cnt      : (XY_SCAN_FRAME_CNT_EN) count of frame_end pulses
// Optional feature macro: XY_SCAN_FRAME_CNT_EN
module xy_scan_counter
  import xy_scan_pkg::*;
#(
  parameter int COL_WIDTH     = DEF_COL_WIDTH,
  parameter int ROW_WIDTH     = DEF_ROW_WIDTH,
  parameter int COL_LIMIT     = DEF_COL_LIMIT,
  parameter int ROW_LIMIT     = DEF_ROW_LIMIT,
  parameter int UP_DOWN_COUNT = 1,
  parameter int SATURATE      = 0
`ifdef XY_SCAN_FRAME_CNT_EN
  ,
  parameter int FRAME_CNT_WIDTH = DEF_FRAME_CNT_WIDTH
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 load,
  input  logic [COL_WIDTH-1:0] col_in,
  input  logic [ROW_WIDTH-1:0] row_in,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 line_end,
  output logic                 frame_end,
  output logic                 done
`ifdef XY_SCAN_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
`endif
);

  logic dir_eff;
  logic done_q;
  logic step;
  logic col_wrap;
  logic row_wrap;
  logic hold;

  assign dir_eff = (UP_DOWN_COUNT != 0) ? dir : 1'b0;
  // load wins over en; a finished saturating frame ignores en entirely.
  assign step    = en & ~load & ~done_q;
  // row_wrap already implies col_wrap (row only steps on a column carry).
  assign hold    = (SATURATE != 0) & row_wrap;

  scan_count_stage #(.WIDTH(COL_WIDTH), .LIMIT(COL_LIMIT)) u_col (
    .clk      (clk),
    .reset    (reset),
    .en       (step),
    .dir      (dir_eff),
    .load     (load),
    .hold     (hold),
    .load_val (col_in),
    .value    (col),
    .wrap     (col_wrap)
  );

  scan_count_stage #(.WIDTH(ROW_WIDTH), .LIMIT(ROW_LIMIT)) u_row (
    .clk      (clk),
    .reset    (reset),
    .en       (col_wrap),
    .dir      (dir_eff),
    .load     (load),
    .hold     (hold),
    .load_val (row_in),
    .value    (row),
    .wrap     (row_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      line_end  <= col_wrap;
      frame_end <= row_wrap;
      if (load)
        done_q <= 1'b0;
      else if (hold)
        done_q <= 1'b1;
    end
  end

  assign done = done_q;

`ifdef XY_SCAN_FRAME_CNT_EN
  // Advances on the same edge that raises frame_end; load never touches it.
  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt <= '0;
    else if (row_wrap)
      frame_cnt <= frame_cnt + FRAME_CNT_WIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_xy_scan_counter.sv
// Bench for xy_scan_counter: a wrapping instance and a saturating instance
// share stimulus; expected outputs are queued at drive time and compared
// one cycle later.
module tb_xy_scan_counter;

  logic       clk = 1'b0;
  logic       reset, en, dir, load;
  logic [2:0] col_in;
  logic [1:0] row_in;

  logic [2:0] col0, col1;
  logic [1:0] row0, row1;
  logic       le0, le1, fe0, fe1, dn0, dn1;
`ifdef XY_SCAN_FRAME_CNT_EN
  logic [7:0] fc0, fc1;
`endif

  always #5 clk = ~clk;

  xy_scan_counter #(.COL_WIDTH(3), .ROW_WIDTH(2), .COL_LIMIT(5), .ROW_LIMIT(2),
                    .UP_DOWN_COUNT(1), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .col_in(col_in), .row_in(row_in), .col(col0), .row(row0),
    .line_end(le0), .frame_end(fe0), .done(dn0)
`ifdef XY_SCAN_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  xy_scan_counter #(.COL_WIDTH(3), .ROW_WIDTH(2), .COL_LIMIT(5), .ROW_LIMIT(2),
                    .UP_DOWN_COUNT(1), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .col_in(col_in), .row_in(row_in), .col(col1), .row(row1),
    .line_end(le1), .frame_end(fe1), .done(dn1)
`ifdef XY_SCAN_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  typedef struct {
    logic [7:0] v0;
    logic [7:0] v1;
    int         fc;
  } exp_t;

  exp_t  sbq[$];
  int    errors = 0;
  int    checks = 0;
  string cur = "init";

  // reference model state, index 0 = wrapping, 1 = saturating
  int mc[2], mr[2];
  bit mle[2], mfe[2], mdn[2];
  int mfc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit ld, input bit e,
                            input bit d, input int ci, input int ri);
    int cs, ct, rs, rt;
    cs = d ? 5 : 0;  ct = d ? 0 : 5;
    rs = d ? 2 : 0;  rt = d ? 0 : 2;
    mle[k] = 0;
    mfe[k] = 0;
    if (r) begin
      mc[k] = 0; mr[k] = 0; mdn[k] = 0;
      if (k == 0) mfc = 0;
    end else if (ld) begin
      mc[k] = (ci > 5) ? 5 : ci;
      mr[k] = (ri > 2) ? 2 : ri;
      mdn[k] = 0;
    end else if (e && !mdn[k]) begin
      if (mc[k] != ct) begin
        mc[k] = d ? mc[k] - 1 : mc[k] + 1;
      end else if (mr[k] != rt) begin
        mc[k] = cs;
        mr[k] = d ? mr[k] - 1 : mr[k] + 1;
        mle[k] = 1;
      end else if (k == 1) begin
        mle[k] = 1; mfe[k] = 1; mdn[k] = 1;
      end else begin
        mc[k] = cs; mr[k] = rs;
        mle[k] = 1; mfe[k] = 1;
        mfc = (mfc + 1) % 256;
      end
    end
  endtask

  function automatic logic [7:0] pack(input int k);
    logic [2:0] c;
    logic [1:0] r;
    c = 3'(mc[k]);
    r = 2'(mr[k]);
    return {c, r, mle[k], mfe[k], mdn[k]};
  endfunction

  task automatic cyc(input bit r, input bit ld, input bit e, input bit d,
                     input int ci, input int ri);
    exp_t x;
    reset = r; load = ld; en = e; dir = d;
    col_in = 3'(ci); row_in = 2'(ri);
    for (int k = 0; k < 2; k++) model_step(k, r, ld, e, d, ci, ri);
    x.v0 = pack(0);
    x.v1 = pack(1);
    x.fc = mfc;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk({cur, "/wrap"}, {24'd0, col0, row0, le0, fe0, dn0}, {24'd0, x.v0});
    chk({cur, "/sat"},  {24'd0, col1, row1, le1, fe1, dn1}, {24'd0, x.v1});
`ifdef XY_SCAN_FRAME_CNT_EN
    chk({cur, "/fcnt"}, {24'd0, fc0}, 32'(x.fc));
`endif
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; col_in = '0; row_in = '0;
    #1;

    cur = "reset";
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);              // no en: hold

    cur = "up_frame";                   // 18 steps, frame_end at (0,0)
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);              // pulses drop without en

    cur = "down";
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0, 0);

    cur = "load_clamp";
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 7, 3);              // load beats en, clamped to (5,2)
    cyc(0, 0, 1, 0, 0, 0);              // -> (0,0) + frame_end

    cur = "saturate";
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);              // load 0,0 clears done
    cyc(0, 0, 1, 0, 0, 0);

    cur = "mid_reset";
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 0);   // reach (3,1)
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);              // -> (1,0)

    cur = "dir_flip";
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);              // down through terminal 0
    cyc(0, 0, 1, 0, 0, 0);

    cur = "frames3";
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 54; i++) cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 2, 1);              // load mid-frame, frame_cnt untouched
    cyc(0, 0, 1, 0, 0, 0);

    cur = "random";
    for (int i = 0; i < 80; i++)
      cyc(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
